branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Next-generation branch unit: resolves all six RV64 conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//  in EX and computes target = PC + sext(imm<<1). Holds a PC-indexed table of saturating counters (BHT)
//  that IF reads for a taken/not-taken prediction. Raises a registered mispredict/redirect to flush IF/ID.
// PARAMETERS
//  DATA_W    64  operand width of rs1/rs2
//  ADDR_W    64  PC / target width
//  BHT_DEPTH 64  number of counter entries; power of two, >=2
//  CNT_W     2   counter width; prediction = counter MSB
// PORTS
//  i_clk           in   1       clock; all state updates on rising edge
//  i_rst_n         in   1       asynchronous, active-low reset
//  i_if_pc         in   ADDR_W  fetch PC for lookup
//  o_pred_taken    out  1       combinational: MSB of BHT[idx(i_if_pc)]
//  i_ex_valid      in   1       EX slot holds a valid instruction
//  i_ex_inst       in   32      EX instruction word
//  i_ex_pc         in   ADDR_W  PC of EX instruction
//  i_ex_pred_taken in   1       prediction made for it at IF (piped down)
//  i_r1, i_r2      in   DATA_W  rs1/rs2 operand values
//  o_br            out  1       registered: resolved branch was taken
//  o_br_addr       out  ADDR_W  registered: computed branch target
//  o_mispredict    out  1       registered 1-cycle pulse: actual != predicted
//  o_redirect_pc   out  ADDR_W  registered: correct next PC (target or PC+4)
//  o_br_cnt        out  32      resolved-branch counter
//  o_mispred_cnt   out  32      mispredict counter
// BEHAVIOUR
//  - idx(pc) = pc[log2(BHT_DEPTH)+1 : 2].
//  - Branch decode: opcode 1100011 with funct3 in {000,001,100,101,110,111}. funct3 010/011 or any
//    other opcode counts as a non-branch.
//  - Compare: signed for BLT/BGE, unsigned for BLTU/BGEU, full DATA_W equality for BEQ/BNE.
//  - imm12 = {inst[31],inst[7],inst[30:25],inst[11:8]}. target = i_ex_pc + sext_ADDR_W({imm12,1'b0}),
//    mod 2^ADDR_W (wraps, no overflow flag). Fall-through = i_ex_pc + 4, also wrapping.
//  - Latency: 1 cycle. A valid branch in EX at edge N drives o_br, o_br_addr, o_mispredict and
//    o_redirect_pc for cycle N+1.
//  - Non-branch or !i_ex_valid at edge N: at N+1, o_br=0 and o_mispredict=0; o_br_addr and
//    o_redirect_pc hold their previous values; no BHT update; no counter change.
//  - BHT update at the same edge: taken -> counter+1, saturating at all-ones; not taken -> counter-1,
//    saturating at 0.
//  - Same-index read/write in one cycle: o_pred_taken returns the pre-update value (no bypass).
//  - o_br_cnt increments per valid resolved branch. o_mispred_cnt increments per mispredict.
//    Both wrap modulo 2^32.
//  - Reset (async, any time, including mid-resolution):
//      * every BHT entry = weakly-not-taken (MSB=0, remaining bits=1; 01 for CNT_W=2);
//      * o_br=0, o_mispredict=0, o_br_addr=0, o_redirect_pc=0, both counters=0;
//      * an in-flight resolution is discarded.
//    After deassertion, the first resolution occurs at the first edge with i_ex_valid=1.
//  - BHT is implemented in flops (no SRAM macro); no handshake; the caller stalls by deasserting
//    i_ex_valid.
// TESTING
//  1. Reset; read every BHT index: o_pred_taken=0. Counters=0, all outputs 0.
//  2. BEQ, pc=0x100, imm12=0x008, r1=r2=5, pred=0:
//     next cycle o_br=1, o_br_addr=0x110, o_mispredict=1, o_redirect_pc=0x110, o_mispred_cnt=1.
//  3. Same BEQ taken 3x at pc=0x100: counter saturates at 11 and o_pred_taken(0x100)=1.
//     Then not taken once: counter 10, prediction still 1.
//  4. BLT vs BLTU, r1=-1, r2=1: BLT taken, BLTU not taken.
//     BGE, pc=0x0, imm12=0xFFE: target = 0xFFFF_FFFF_FFFF_FFFC (wrap).
//  5. funct3=010 with opcode 1100011, and an ADD, with i_ex_valid=1:
//     o_br=0, o_mispredict=0, BHT and counters unchanged.
//  6. Assert i_rst_n=0 mid-cycle while a mispredicting branch is in EX:
//     o_mispredict never pulses, BHT returns to 01, counters = 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Conditional-branch resolver for RV64 with a PC-indexed BHT of saturating counters.
// Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU in EX. Outputs are registered except o_pred_taken,
// which is a combinational IF-stage lookup.
`timescale 1ns/1ps
module branch_predict_unit #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CNT_W     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_if_pc,
    output logic              o_pred_taken,
    input  logic              i_ex_valid,
    input  logic [31:0]       i_ex_inst,
    input  logic [ADDR_W-1:0] i_ex_pc,
    input  logic              i_ex_pred_taken,
    input  logic [DATA_W-1:0] i_r1,
    input  logic [DATA_W-1:0] i_r2,
    output logic              o_br,
    output logic [ADDR_W-1:0] o_br_addr,
    output logic              o_mispredict,
    output logic [ADDR_W-1:0] o_redirect_pc,
    output logic [31:0]       o_br_cnt,
    output logic [31:0]       o_mispred_cnt
);
    localparam int unsigned     IDX_W      = $clog2(BHT_DEPTH);
    localparam int unsigned     IMM_W      = 13;
    localparam logic [6:0]      OPC_BRANCH = 7'b1100011;
    localparam logic [CNT_W-1:0] CNT_WNT   = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [CNT_W-1:0]  bht [BHT_DEPTH];
    logic [IDX_W-1:0]  if_idx_c;
    logic [IDX_W-1:0]  ex_idx_c;
    logic [2:0]        funct3_c;
    logic              is_branch_c;
    logic              eq_c;
    logic              lt_c;
    logic              ltu_c;
    logic              taken_c;
    logic              resolve_c;
    logic              mispred_c;
    logic [IMM_W-1:0]  imm13_c;
    logic [ADDR_W-1:0] target_c;
    logic [ADDR_W-1:0] fall_c;
    logic [ADDR_W-1:0] redirect_c;

    // PC bits outside the index and instruction register fields are intentionally ignored
    logic unused_ok;
    assign unused_ok = ^{i_if_pc[ADDR_W-1:IDX_W+2], i_if_pc[1:0], i_ex_inst[24:15]};

    // IF-stage lookup; reads the pre-update value when EX writes the same entry
    assign if_idx_c     = i_if_pc[IDX_W+1:2];
    assign o_pred_taken = bht[if_idx_c][CNT_W-1];

    // Decode, compare and target generation for the EX instruction
    always_comb begin
        ex_idx_c    = i_ex_pc[IDX_W+1:2];
        funct3_c    = i_ex_inst[14:12];
        is_branch_c = 1'b0;
        taken_c     = 1'b0;
        if (i_ex_inst[6:0] == OPC_BRANCH) begin
            is_branch_c = (funct3_c != 3'b010) && (funct3_c != 3'b011);
        end
        eq_c  = (i_r1 == i_r2);
        lt_c  = ($signed(i_r1) < $signed(i_r2));
        ltu_c = (i_r1 < i_r2);
        case (funct3_c)
            3'b000:  taken_c = eq_c;
            3'b001:  taken_c = !eq_c;
            3'b100:  taken_c = lt_c;
            3'b101:  taken_c = !lt_c;
            3'b110:  taken_c = ltu_c;
            3'b111:  taken_c = !ltu_c;
            default: taken_c = 1'b0;
        endcase
        imm13_c    = {i_ex_inst[31], i_ex_inst[7], i_ex_inst[30:25], i_ex_inst[11:8], 1'b0};
        target_c   = i_ex_pc + {{(ADDR_W - IMM_W){imm13_c[IMM_W-1]}}, imm13_c};
        fall_c     = i_ex_pc + ADDR_W'(4);
        redirect_c = taken_c ? target_c : fall_c;
        resolve_c  = i_ex_valid && is_branch_c;
        mispred_c  = resolve_c && (taken_c != i_ex_pred_taken);
    end

    // Registered resolution results; addresses hold when nothing resolves
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_br          <= 1'b0;
            o_mispredict  <= 1'b0;
            o_br_addr     <= '0;
            o_redirect_pc <= '0;
        end else begin
            o_br         <= resolve_c && taken_c;
            o_mispredict <= mispred_c;
            if (resolve_c) begin
                o_br_addr     <= target_c;
                o_redirect_pc <= redirect_c;
            end
        end
    end

    // Saturating counter update of the entry selected by the EX PC
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CNT_WNT;
            end
        end else if (resolve_c) begin
            if (taken_c && (bht[ex_idx_c] != CNT_MAX)) begin
                bht[ex_idx_c] <= bht[ex_idx_c] + CNT_W'(1);
            end else if (!taken_c && (bht[ex_idx_c] != '0)) begin
                bht[ex_idx_c] <= bht[ex_idx_c] - CNT_W'(1);
            end
        end
    end

    // Resolved-branch and mispredict event counters, wrapping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_br_cnt      <= '0;
            o_mispred_cnt <= '0;
        end else begin
            if (resolve_c) begin
                o_br_cnt <= o_br_cnt + 32'd1;
            end
            if (mispred_c) begin
                o_mispred_cnt <= o_mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a behavioural model pushes expected
// results when EX stimulus is driven; they are popped and compared after the edge.
`timescale 1ns/1ps
module tb_branch_predict_unit;

    typedef struct {
        logic        br;
        logic [63:0] addr;
        logic        mis;
        logic [63:0] redir;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic [31:0] ex_inst;
    logic [63:0] ex_pc;
    logic        ex_pred;
    logic [63:0] r1;
    logic [63:0] r2;
    logic        br;
    logic [63:0] br_addr;
    logic        mispredict;
    logic [63:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    exp_t        sb[$];
    logic [1:0]  bht_m [64];
    logic        br_m;
    logic        mis_m;
    logic [63:0] addr_m;
    logic [63:0] redir_m;
    logic [31:0] bc_m;
    logic [31:0] mc_m;
    int          n_checks;
    int          n_fail;

    branch_predict_unit dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_if_pc         (if_pc),
        .o_pred_taken    (pred_taken),
        .i_ex_valid      (ex_valid),
        .i_ex_inst       (ex_inst),
        .i_ex_pc         (ex_pc),
        .i_ex_pred_taken (ex_pred),
        .i_r1            (r1),
        .i_r2            (r2),
        .o_br            (br),
        .o_br_addr       (br_addr),
        .o_mispredict    (mispredict),
        .o_redirect_pc   (redirect_pc),
        .o_br_cnt        (br_cnt),
        .o_mispred_cnt   (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] b_inst(input logic [2:0] f3, input logic [11:0] imm);
        return {imm[11], imm[9:4], 5'd2, 5'd1, f3, imm[3:0], imm[10], 7'h63};
    endfunction

    function automatic longint off_of(input logic [11:0] imm);
        longint v;
        v = longint'({52'd0, imm});
        if (imm[11]) v = v - 4096;
        return v * 2;
    endfunction

    function automatic logic pred_of(input logic [63:0] pc);
        logic [1:0] c;
        c = bht_m[int'(pc[7:2])];
        return c[1];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
        br_m = 1'b0; mis_m = 1'b0; addr_m = '0; redir_m = '0; bc_m = '0; mc_m = '0;
        sb.delete();
    endtask

    task automatic check_all_pred(input string tag);
        for (int i = 0; i < 64; i++) begin
            if_pc = 64'(i) << 2;
            #1;
            check_val(tag, {63'd0, pred_taken}, {63'd0, pred_of(if_pc)});
        end
    endtask

    // One EX cycle: drive, model, push expectation, clock, pop and compare
    task automatic ex_cycle(input logic v, input logic [31:0] inst, input logic [11:0] imm,
                            input logic [63:0] pc, input logic pred,
                            input logic [63:0] a, input logic [63:0] b);
        exp_t   e;
        logic   tk;
        logic   [2:0] f3;
        longint sa;
        longint sbv;
        int     idx;
        @(negedge clk);
        ex_valid = v; ex_inst = inst; ex_pc = pc; ex_pred = pred; r1 = a; r2 = b; if_pc = pc;
        #1;
        idx = int'(pc[7:2]);
        check_val("pred_before_edge", {63'd0, pred_taken}, {63'd0, pred_of(pc)});
        f3 = inst[14:12];
        sa = a; sbv = b;
        if (v && inst[6:0] == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
            case (f3)
                3'd0:    tk = (a == b);
                3'd1:    tk = (a != b);
                3'd4:    tk = (sa < sbv);
                3'd5:    tk = !(sa < sbv);
                3'd6:    tk = (a < b);
                default: tk = !(a < b);
            endcase
            br_m    = tk;
            addr_m  = pc + 64'(off_of(imm));
            redir_m = tk ? addr_m : pc + 64'd4;
            mis_m   = (tk != pred);
            bc_m    = bc_m + 32'd1;
            if (mis_m) mc_m = mc_m + 32'd1;
            if (tk && bht_m[idx] != 2'b11) bht_m[idx] = bht_m[idx] + 2'd1;
            else if (!tk && bht_m[idx] != 2'b00) bht_m[idx] = bht_m[idx] - 2'd1;
        end else begin
            br_m  = 1'b0;
            mis_m = 1'b0;
        end
        e.br = br_m; e.addr = addr_m; e.mis = mis_m; e.redir = redir_m; e.bc = bc_m; e.mc = mc_m;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty");
        end else begin
            e = sb.pop_front();
            check_val("o_br",          {63'd0, br},         {63'd0, e.br});
            check_val("o_br_addr",     br_addr,             e.addr);
            check_val("o_mispredict",  {63'd0, mispredict}, {63'd0, e.mis});
            check_val("o_redirect_pc", redirect_pc,         e.redir);
            check_val("o_br_cnt",      {32'd0, br_cnt},     {32'd0, e.bc});
            check_val("o_mispred_cnt", {32'd0, mispred_cnt}, {32'd0, e.mc});
            check_val("pred_after_edge", {63'd0, pred_taken}, {63'd0, pred_of(pc)});
        end
    endtask

    initial begin
        logic [2:0]  f3s [6];
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [63:0] pc;
        logic [63:0] a;
        logic [63:0] b;
        n_checks = 0; n_fail = 0;
        f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd4; f3s[3] = 3'd5; f3s[4] = 3'd6; f3s[5] = 3'd7;
        rst_n = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_inst = '0; ex_pc = '0; ex_pred = 1'b0;
        r1 = '0; r2 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state
        check_val("rst_o_br",          {63'd0, br},          64'd0);
        check_val("rst_o_mispredict",  {63'd0, mispredict},  64'd0);
        check_val("rst_o_br_addr",     br_addr,              64'd0);
        check_val("rst_o_redirect_pc", redirect_pc,          64'd0);
        check_val("rst_o_br_cnt",      {32'd0, br_cnt},      64'd0);
        check_val("rst_o_mispred_cnt", {32'd0, mispred_cnt}, 64'd0);
        check_all_pred("rst_bht_pred");

        // BEQ taken, mispredicted
        ex_cycle(1'b1, b_inst(3'd0, 12'h008), 12'h008, 64'h100, 1'b0, 64'd5, 64'd5);
        check_val("beq_target_abs", br_addr, 64'h110);
        // Saturate, then one not-taken
        repeat (3) ex_cycle(1'b1, b_inst(3'd0, 12'h008), 12'h008, 64'h100, pred_of(64'h100), 64'd5, 64'd5);
        check_val("bht_sat_abs", {62'd0, bht_m[0]}, 64'd3);
        ex_cycle(1'b1, b_inst(3'd0, 12'h008), 12'h008, 64'h100, pred_of(64'h100), 64'd5, 64'd6);

        // Signed vs unsigned compare, backward wrap target
        ex_cycle(1'b1, b_inst(3'd4, 12'h010), 12'h010, 64'h200, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        ex_cycle(1'b1, b_inst(3'd6, 12'h010), 12'h010, 64'h200, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        ex_cycle(1'b1, b_inst(3'd5, 12'hFFE), 12'hFFE, 64'h0, 1'b0, 64'd1, 64'd1);
        check_val("bge_wrap_abs", br_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        // Fall-through wrap at top of address space
        ex_cycle(1'b1, b_inst(3'd1, 12'h004), 12'h004, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'd7, 64'd7);

        // Non-branches and invalid slot leave everything untouched
        ex_cycle(1'b1, b_inst(3'd2, 12'h020), 12'h020, 64'h100, 1'b1, 64'd1, 64'd1);
        ex_cycle(1'b1, b_inst(3'd3, 12'h020), 12'h020, 64'h104, 1'b0, 64'd1, 64'd2);
        ex_cycle(1'b1, 32'h0020_81B3, 12'h000, 64'h100, 1'b0, 64'd3, 64'd3);
        ex_cycle(1'b0, b_inst(3'd0, 12'h040), 12'h040, 64'h100, 1'b0, 64'd3, 64'd3);
        check_all_pred("nonbr_bht_pred");

        // Random branch mix
        for (int k = 0; k < 40; k++) begin
            f3  = f3s[$urandom_range(5, 0)];
            imm = 12'($urandom);
            pc  = 64'($urandom_range(31, 0)) << 2;
            a   = {32'($urandom), 32'($urandom)};
            b   = ($urandom_range(3, 0) == 0) ? a : {32'($urandom), 32'($urandom)};
            ex_cycle($urandom_range(4, 0) != 0, b_inst(f3, imm), imm, pc, pred_of(pc), a, b);
        end

        // Async reset while a mispredicting branch sits in EX
        @(negedge clk);
        ex_valid = 1'b1; ex_inst = b_inst(3'd0, 12'h008); ex_pc = 64'h100; ex_pred = 1'b0;
        r1 = 64'd9; r2 = 64'd9;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rstmid_o_mispredict", {63'd0, mispredict}, 64'd0);
        check_val("rstmid_o_br_cnt",     {32'd0, br_cnt},     64'd0);
        @(posedge clk);
        #1;
        check_val("rstmid_edge_mispredict", {63'd0, mispredict},  64'd0);
        check_val("rstmid_edge_o_br",       {63'd0, br},          64'd0);
        check_val("rstmid_mispred_cnt",     {32'd0, mispred_cnt}, 64'd0);
        check_val("rstmid_redirect_pc",     redirect_pc,          64'd0);
        model_reset();
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n = 1'b1;
        check_all_pred("rstmid_bht_pred");
        // Entry is back to 01: one taken outcome lifts prediction to 1
        ex_cycle(1'b1, b_inst(3'd0, 12'h008), 12'h008, 64'h100, 1'b0, 64'd5, 64'd5);
        check_val("post_rst_pred_abs", {63'd0, pred_taken}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
